regfile_dump_reader: RTL



---
 rtl/regfile_dump_reader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// regfile_dump_reader
//
// Read-side debug initiator for the register file. When start is pulsed, it
// walks the register address range first_addr..last_addr (5-bit, wrapping
// 31 -> 0) through one register-file read port. Each 32-bit value is
// captured once and presented as an (address, data) word on a valid/ready
// output stream. The block never writes. It only borrows a read port that is
// idle while the core is halted.
//
// Parameters:
//   NUM_REGS       number of implemented registers; higher addresses stream 0
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high reset
//   start          one-cycle dump request (ignored while busy)
//   first_addr     first register of the range, sampled on accepted start
//   last_addr      last register of the range, sampled on accepted start
//   abort          cancels a dump in progress (no done pulse)
//   reg_read_Addr  address driven to the register-file read port
//   reg_read_Data  combinational read data from the register file
//   out_valid      output word available
//   out_ready      consumer accepts the word this cycle
//   out_addr       register address of the current word
//   out_data       captured register value
//   out_last       current word is the final one of the range
//   busy           high from accepted start until return to idle
//   done           one-cycle pulse after the final word is accepted
// ---------------------------------------------------------------------------
module regfile_dump_reader #(
  parameter int unsigned NUM_REGS = 19
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  first_addr,
  input  logic [4:0]  last_addr,
  input  logic        abort,
  output logic [4:0]  reg_read_Addr,
  input  logic [31:0] reg_read_Data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_addr,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ   = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [31:0] NUM_REGS_W = 32'(NUM_REGS);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cur_q, cur_d;
  logic [4:0]  end_q, end_d;
  logic        out_valid_q, out_valid_d;
  logic [4:0]  out_addr_q, out_addr_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Registers at or above NUM_REGS do not exist, so they stream as zero
  // instead of whatever the read port happens to return.
  logic        cur_unimpl;
  assign cur_unimpl = ({27'd0, cur_q} >= NUM_REGS_W);

  // Next-state and datapath logic. Abort takes priority over the capture in
  // READ and over acceptance in HOLD. Either way the dump is dropped with no
  // done pulse.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    end_d       = end_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = first_addr;
          end_d   = last_addr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_data_d  = cur_unimpl ? 32'h0 : reg_read_Data;
          out_addr_d  = cur_q;
          out_last_d  = (cur_q == end_q);
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = S_FINISH;
          end else begin
            // 5-bit add wraps 31 -> 0 so ranges may cross the top
            cur_d   = cur_q + 5'd1;
            state_d = S_READ;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy and done are registered copies of where the FSM is heading, so
    // they line up exactly with the state they describe.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_q       <= 5'd0;
      end_q       <= 5'd0;
      out_valid_q <= 1'b0;
      out_addr_q  <= 5'd0;
      out_data_q  <= 32'h0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The read port only carries cur while a word is being read or held.
  // Because state_q and cur_q are flops, this still changes only on edges.
  assign reg_read_Addr = ((state_q == S_READ) || (state_q == S_HOLD)) ? cur_q : 5'd0;

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
